mem_access_stage: RTL and testbench

Memory stage placed directly downstream of the execute ALU. It consumes the registered ALU result as an address or pass-through value and performs word/byte loads and stores over a req/ack data-memory port. It then presents a one-cycle writeback packet to the register-file writeback stage. While a memory access is outstanding it back-pressures execute through in_ready.

---
 rtl/mem_access_stage.sv | 116 +++++++++++
 tb/tb_mem_access_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage issuing word/byte loads and stores over a req/ack port
// and emitting a one-cycle writeback packet; an access that outlasts TIMEOUT cycles is aborted with err_bus.
module mem_access_stage #(
   parameter int WORD_SIZE = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_SIZE-1:0]   alu_result,
   input  logic [WORD_SIZE-1:0]   store_data,
   input  logic                   mem_read,
   input  logic                   mem_write,
   input  logic                   byte_op,
   input  logic                   load_unsigned,
   input  logic [4:0]             rd,
   input  logic                   reg_write,
   output logic                   dmem_req,
   output logic                   dmem_we,
   output logic [WORD_SIZE-1:0]   dmem_addr,
   output logic [WORD_SIZE-1:0]   dmem_wdata,
   output logic [WORD_SIZE/8-1:0] dmem_be,
   input  logic                   dmem_ack,
   input  logic [WORD_SIZE-1:0]   dmem_rdata,
   output logic                   wb_valid,
   output logic [4:0]             wb_rd,
   output logic [WORD_SIZE-1:0]   wb_data,
   output logic                   wb_reg_write,
   output logic                   err_misaligned,
   output logic                   err_bus
);
   localparam int BL = WORD_SIZE / 8;
   localparam int CW = $clog2(TIMEOUT) + 1;
   typedef enum logic {IDLE, WAIT} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic l_byte, l_uns, l_rw;
   logic [4:0] l_rd;
   logic is_mem, illegal;
   logic [7:0] lane;
   logic [WORD_SIZE-1:0] load_val;
   assign in_ready = state == IDLE;
   always_comb begin
      is_mem = mem_read | mem_write;
      illegal = (mem_read & mem_write) | (!byte_op && alu_result[1:0] != 2'b00);
      lane = 8'(dmem_rdata >> {dmem_addr[1:0], 3'b000});
      load_val = l_byte ? {{(WORD_SIZE-8){l_uns ? 1'b0 : lane[7]}}, lane} : dmem_rdata;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         dmem_req <= 1'b0;
         dmem_we <= 1'b0;
         dmem_addr <= '0;
         dmem_wdata <= '0;
         dmem_be <= '0;
         wb_valid <= 1'b0;
         wb_rd <= '0;
         wb_data <= '0;
         wb_reg_write <= 1'b0;
         err_misaligned <= 1'b0;
         err_bus <= 1'b0;
         l_byte <= 1'b0;
         l_uns <= 1'b0;
         l_rw <= 1'b0;
         l_rd <= '0;
      end else begin
         wb_valid <= 1'b0;
         err_misaligned <= 1'b0;
         err_bus <= 1'b0;
         if (state == IDLE) begin
            if (in_valid && (!is_mem || illegal)) begin
               wb_valid <= 1'b1;
               wb_data <= alu_result;
               wb_rd <= rd;
               wb_reg_write <= !is_mem && reg_write;
               err_misaligned <= is_mem;
            end else if (in_valid) begin
               state <= WAIT;
               cnt <= '0;
               dmem_req <= 1'b1;
               dmem_we <= mem_write;
               dmem_addr <= alu_result;
               dmem_be <= byte_op ? BL'(1) << alu_result[1:0] : '1;
               dmem_wdata <= byte_op ? {BL{store_data[7:0]}} : store_data;
               l_byte <= byte_op;
               l_uns <= load_unsigned;
               l_rw <= reg_write;
               l_rd <= rd;
            end
         end else if (dmem_ack) begin
            state <= IDLE;
            cnt <= '0;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd <= l_rd;
            wb_data <= dmem_we ? '0 : load_val;
            wb_reg_write <= !dmem_we && l_rw;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            // abort: the request has been held TIMEOUT cycles without an ack
            state <= IDLE;
            cnt <= '0;
            dmem_req <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd <= l_rd;
            wb_data <= '0;
            wb_reg_write <= 1'b0;
            err_bus <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized bench; expected per-cycle outputs are scheduled
// from transaction-level rules and compared every cycle.
module tb_mem_access_stage;
   localparam int TO = 4;
   localparam int MAXC = 4096;
   logic clk = 0, rst = 0;
   logic in_valid = 0, in_ready;
   logic [31:0] alu_result = 0, store_data = 0;
   logic mem_read = 0, mem_write = 0, byte_op = 0, load_unsigned = 0, reg_write = 0;
   logic [4:0] rd = 0;
   logic dmem_req, dmem_we, dmem_ack = 0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
   logic [3:0] dmem_be;
   logic wb_valid, wb_reg_write, err_misaligned, err_bus;
   logic [4:0] wb_rd;
   logic [31:0] wb_data;
   int total = 0, bad = 0, cyc = 0;
   bit chk_on = 0;
   bit exp_wbv [MAXC], exp_rw [MAXC], exp_mis [MAXC], exp_bus [MAXC];
   bit chk_data [MAXC], chk_rd [MAXC], exp_ready [MAXC];
   bit [31:0] exp_data [MAXC];
   bit [4:0] exp_rd [MAXC];
   bit exp_req [MAXC], exp_we [MAXC], chk_st [MAXC];
   bit [31:0] exp_addr [MAXC], exp_wdata [MAXC];
   bit [3:0] exp_be [MAXC];

   mem_access_stage #(.WORD_SIZE(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
      .mem_write(mem_write), .byte_op(byte_op), .load_unsigned(load_unsigned),
      .rd(rd), .reg_write(reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_reg_write(wb_reg_write),
      .err_misaligned(err_misaligned), .err_bus(err_bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h want=%h", n, cyc, a, e);
      end
   endfunction

   // reference rules expressed arithmetically
   function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [31:0] addr,
                                          input logic bop, input logic uns);
      int unsigned b;
      if (!bop) return rdata;
      b = (rdata / (32'd1 << (8 * (addr % 4)))) % 256;
      if (!uns && b >= 128) return 32'(b) - 32'd256;
      return 32'(b);
   endfunction
   function automatic logic [3:0] m_be(input logic [31:0] addr, input logic bop);
      return bop ? 4'(1 << (addr % 4)) : 4'd15;
   endfunction
   function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic bop);
      return bop ? (sd % 256) * 32'h0101_0101 : sd;
   endfunction

   always @(negedge clk) if (chk_on && cyc < MAXC) begin
      chk("in_ready", in_ready, exp_ready[cyc]);
      chk("wb_valid", wb_valid, exp_wbv[cyc]);
      chk("err_misaligned", err_misaligned, exp_mis[cyc]);
      chk("err_bus", err_bus, exp_bus[cyc]);
      chk("dmem_req", dmem_req, exp_req[cyc]);
      if (exp_wbv[cyc]) chk("wb_reg_write", wb_reg_write, exp_rw[cyc]);
      if (exp_wbv[cyc] && chk_data[cyc]) chk("wb_data", wb_data, exp_data[cyc]);
      if (exp_wbv[cyc] && chk_rd[cyc]) chk("wb_rd", wb_rd, exp_rd[cyc]);
      if (exp_req[cyc]) begin
         chk("dmem_we", dmem_we, exp_we[cyc]);
         chk("dmem_addr", dmem_addr, exp_addr[cyc]);
      end
      if (exp_req[cyc] && chk_st[cyc]) begin
         chk("dmem_be", dmem_be, exp_be[cyc]);
         chk("dmem_wdata", dmem_wdata, exp_wdata[cyc]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage();
      in_valid = 1'($urandom);
      alu_result = $urandom;
      store_data = $urandom;
      mem_read = 1'($urandom);
      mem_write = 1'($urandom);
      byte_op = 1'($urandom);
      rd = 5'($urandom);
   endtask

   // issue one op in the current cycle; d = cycles of dmem_req before ack (>= TO means no ack)
   task automatic do_op(input logic rdv, input logic wrv, input logic bop, input logic uns,
                        input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rdi,
                        input logic rwi, input int d, input logic [31:0] rdata);
      int a, n, w;
      bit tout;
      a = cyc + 1;
      in_valid = 1; mem_read = rdv; mem_write = wrv; byte_op = bop; load_unsigned = uns;
      alu_result = alu; store_data = sd; rd = rdi; reg_write = rwi; dmem_ack = 0;
      if (a + TO + 2 >= MAXC) begin
         in_valid = 0;
         return;
      end
      if (!rdv && !wrv) begin
         exp_wbv[a] = 1; exp_data[a] = alu; chk_data[a] = 1;
         exp_rd[a] = rdi; chk_rd[a] = 1; exp_rw[a] = rwi;
         tick();
         in_valid = 0;
         return;
      end
      if ((rdv && wrv) || (!bop && alu % 4 != 0)) begin
         exp_wbv[a] = 1; exp_data[a] = alu; chk_data[a] = 1; exp_rw[a] = 0; exp_mis[a] = 1;
         tick();
         in_valid = 0;
         return;
      end
      tout = d >= TO;
      n = tout ? TO : d + 1;
      w = a + n;
      for (int j = 0; j < n; j++) begin
         exp_req[a+j] = 1; exp_we[a+j] = wrv; exp_addr[a+j] = alu; exp_ready[a+j] = 0;
         chk_st[a+j] = wrv; exp_be[a+j] = m_be(alu, bop); exp_wdata[a+j] = m_wdata(sd, bop);
      end
      exp_wbv[w] = 1;
      exp_bus[w] = tout;
      exp_rw[w] = !tout && !wrv && rwi;
      if (!tout && !wrv) begin
         exp_data[w] = m_load(rdata, alu, bop, uns); chk_data[w] = 1;
         exp_rd[w] = rdi; chk_rd[w] = 1;
      end
      tick();
      for (int j = 0; j < n; j++) begin
         garbage();
         dmem_ack = (j == d);
         dmem_rdata = (j == d) ? rdata : $urandom;
         tick();
      end
      dmem_ack = 0;
      in_valid = 0;
   endtask

   initial begin
      for (int i = 0; i < MAXC; i++) exp_ready[i] = 1;
      tick(); tick();
      chk("rst dmem_req", dmem_req, 0);
      chk("rst dmem_we", dmem_we, 0);
      chk("rst dmem_addr", dmem_addr, 0);
      chk("rst dmem_wdata", dmem_wdata, 0);
      chk("rst dmem_be", dmem_be, 0);
      chk("rst wb_valid", wb_valid, 0);
      chk("rst wb_rd", wb_rd, 0);
      chk("rst wb_data", wb_data, 0);
      chk("rst wb_reg_write", wb_reg_write, 0);
      chk("rst err_misaligned", err_misaligned, 0);
      chk("rst err_bus", err_bus, 0);
      chk("rst in_ready", in_ready, 1);
      rst = 1;
      chk_on = 1;
      chk("model sext byte", m_load(32'h80FF_1234, 32'h103, 1, 0), 32'hFFFF_FF80);
      chk("model zext byte", m_load(32'h80FF_1234, 32'h103, 1, 1), 32'h0000_0080);
      chk("model byte be", m_be(32'h102, 1), 4'b0100);
      chk("model byte wdata", m_wdata(32'h0000_00AB, 1), 32'hABAB_ABAB);
      chk("model word wdata", m_wdata(32'hDEAD_BEEF, 0), 32'hDEAD_BEEF);
      do_op(0, 0, 0, 0, 32'h2A, 0, 5, 1, 0, 0);
      do_op(0, 0, 0, 0, 32'h55, 0, 6, 1, 0, 0);
      do_op(0, 1, 0, 0, 32'h100, 32'hDEAD_BEEF, 1, 1, 2, 0);
      do_op(1, 0, 1, 0, 32'h103, 0, 7, 1, 0, 32'h80FF_1234);
      do_op(1, 0, 1, 1, 32'h103, 0, 8, 1, 0, 32'h80FF_1234);
      do_op(0, 1, 1, 0, 32'h102, 32'hAB, 2, 0, 1, 0);
      do_op(1, 0, 0, 0, 32'h101, 0, 9, 1, 0, 0);
      do_op(1, 0, 0, 0, 32'h200, 0, 10, 1, 99, 0);
      tick();
      begin : mid_reset
         int a;
         a = cyc + 1;
         in_valid = 1; mem_read = 1; mem_write = 0; byte_op = 0; alu_result = 32'h300; reg_write = 1;
         for (int j = 0; j < 2; j++) begin
            exp_req[a+j] = 1; exp_we[a+j] = 0; exp_addr[a+j] = 32'h300; exp_ready[a+j] = 0;
         end
         tick();
         in_valid = 0;
         tick();
         rst = 0;
         tick();
         rst = 1;
         chk("mid-reset dmem_req", dmem_req, 0);
         chk("mid-reset dmem_addr", dmem_addr, 0);
         chk("mid-reset wb_valid", wb_valid, 0);
         dmem_ack = 1; dmem_rdata = 32'h1234_5678;
         tick(); tick();
         dmem_ack = 0;
      end
      do_op(0, 0, 0, 0, 32'h77, 0, 3, 1, 0, 0);
      repeat (300) begin
         int r, g;
         logic bop;
         logic [31:0] alu;
         g = $urandom_range(0, 2);
         for (int k = 0; k < g; k++) begin
            in_valid = 0; dmem_ack = 1'($urandom); dmem_rdata = $urandom;
            tick();
         end
         r = $urandom_range(0, 9);
         bop = 1'($urandom);
         alu = $urandom;
         if ($urandom_range(0, 3) != 0 && !bop) alu[1:0] = 2'b00;
         do_op(r >= 3 && r <= 5 || r == 9, r >= 6, bop, 1'($urandom), alu, $urandom,
               5'($urandom), 1'($urandom), $urandom_range(0, 5), $urandom);
      end
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
